// File: rtl/hypot_seq.sv
// Sequenced integer hypotenuse: floor(sqrt(x^2 + y^2)) using one shared squarer
// and a restoring square root that resolves one result bit per cycle, MSB first.
module hypot_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         clear,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   result,
    output logic         exact,
    output logic         busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQX  = 3'd1,
        SQY  = 3'd2,
        ROOT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [2*W-1:0]  sq_q, sq_d;
    logic [2*W+1:0]  rad_q, rad_d;
    logic [W+1:0]    rem_q, rem_d;
    logic [W:0]      root_q, root_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      result_q, result_d;
    logic            exact_q, exact_d;

    logic [2*W-1:0]  mul_op;
    logic [2*W-1:0]  product;
    logic [W+3:0]    rem_sh;
    logic [W+3:0]    trial;
    logic [W+3:0]    rem_full;
    logic            ge;
    logic [W:0]      root_nx;

    // Single squarer shared between the X and Y phases
    assign mul_op  = {{W{1'b0}}, (state_q == SQX) ? x_q : y_q};
    assign product = mul_op * mul_op;

    // One restoring step: bring down the next radicand bit pair, try 4*root+1
    assign rem_sh   = {rem_q, rad_q[2*W+1 -: 2]};
    assign trial    = {1'b0, root_q, 2'b01};
    assign ge       = (rem_sh >= trial);
    assign rem_full = ge ? (rem_sh - trial) : rem_sh;
    assign root_nx  = {root_q[W-1:0], ge};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sq_d     = sq_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exact_d  = exact_q;

        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_d     = x;
                        y_d     = y;
                        state_d = SQX;
                    end
                end
                SQX: begin
                    sq_d    = product;
                    state_d = SQY;
                end
                SQY: begin
                    rad_d   = {1'b0, {1'b0, sq_q} + {1'b0, product}};
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(W);
                    state_d = ROOT;
                end
                ROOT: begin
                    rad_d  = {rad_q[2*W-1:0], 2'b00};
                    rem_d  = rem_full[W+1:0];
                    root_d = root_nx;
                    if (cnt_q == '0) begin
                        result_d = root_nx;
                        exact_d  = (rem_full == '0);
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            sq_q     <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sq_q     <= sq_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exact_q  <= exact_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign exact     = exact_q;

endmodule
